cpu86_exec_register_writer: RTL and testbench
=============================================

CPU86_EXEC_REGISTER_WRITER -- requirements
Module: cpu86_exec_register_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have wb_valid in 1, wb_ready out 1: writeback request handshake; transfer occurs when both are high on a clk edge.
REQ-004 SHALL have wb_dreg in 4, wb_w in 1, wb_data in 16: destination code, word(1)/byte(0) select, and write data.
REQ-005 SHALL have iss_valid in 1, iss_ready out 1, iss_dreg in 4: issue-side reservation of a destination register.
REQ-006 SHALL have hold in 1: when high, writeback retirement is frozen.
REQ-007 SHALL have ax, bx, cx, dx, sp, bp, si, di, es, cs, ss, ds, fl outputs, 16 bits each: registered architectural state.
REQ-008 SHALL have busy out 16: bit n high while register code n has pending reservations.
REQ-009 SHALL have parameter DEPTH, default 2: writeback buffer entries, legal values 2 to 4.

Function
REQ-010 Word code map SHALL be: 0 AX, 1 CX, 2 DX, 3 BX, 4 SP, 5 BP, 6 SI, 7 DI, 8 ES, 9 CS, 10 SS, 11 DS, 12 FL; codes 13-15 SHALL be accepted and discarded.
REQ-011 Byte map (wb_w=0) SHALL be: codes 0-3 write the low byte of AX/CX/DX/BX, codes 4-7 write the high byte of AX/CX/DX/BX, using wb_data[7:0]; other byte codes SHALL be accepted and discarded.
REQ-012 Accepted requests SHALL enter a FIFO of DEPTH entries; wb_ready SHALL equal "FIFO not full", with no combinational dependence on wb_valid.
REQ-013 With hold low and the FIFO non-empty, the head entry SHALL retire (register updated) on each clk edge; only one retirement per cycle.
REQ-014 A request accepted at edge N with an empty FIFO and hold low SHALL be visible on the register outputs after edge N+1; latency is 1 cycle per queued entry ahead of it.
REQ-015 With hold high, no entry SHALL retire; accepts SHALL continue until full; the FIFO SHALL NOT overflow or drop entries.
REQ-016 Simultaneous accept and retire on a full FIFO SHALL NOT be allowed, because wb_ready is low when the FIFO is full.
REQ-017 Byte writes SHALL preserve the other byte of the target register.
REQ-018 Each register code SHALL have a 3-bit pending counter: +1 on iss handshake, -1 on retirement of that code; simultaneous +1 and -1 on the same code SHALL leave the counter unchanged.
REQ-019 A byte code 4-7 SHALL map to counter index 0-3, the parent register; discarded codes SHALL NOT touch any counter.
REQ-020 iss_ready SHALL be low when the counter for iss_dreg equals 7, except when a retirement of that same code occurs in the same cycle.
REQ-021 Retirement of a code whose counter is 0 SHALL update the register and leave the counter at 0; the counter SHALL NOT underflow.
REQ-022 busy[n] SHALL be registered, equal to (counter[n] != 0) after each edge; busy[15:13] SHALL be 0.

Reset
REQ-023 On reset: FIFO empty, wb_ready=1, iss_ready=1, all counters 0, busy=0.
REQ-024 On reset: all general and segment registers SHALL be 16'h0000, except cs=16'hFFFF; fl SHALL be 16'hF002.
REQ-025 Reset asserted mid-operation SHALL discard queued and partially accepted entries immediately, with no retirement on the reset edge.

Structure
REQ-026 The register-code enumeration (REQ-010/011) and the reset constants SHALL live in a shared package, cpu86_types_pkg, used with the matching register reader.
REQ-027 The writeback FIFO SHALL be one sub-module, cpu86_wb_fifo, parameterised by DEPTH and data width (21 bits).

Verification
REQ-028 After reset, outputs SHALL read cs=FFFF, fl=F002, all other registers 0000, busy=0000, and both ready signals high.
REQ-029 A word write with dreg=3, data=1234 is accepted; the next edge SHALL give bx=1234. A following byte write with dreg=7, data=00AB SHALL give bx=AB34.
REQ-030 With hold=1, three writes are offered at DEPTH=2. wb_ready SHALL drop after 2 accepts. After hold is released, the entries SHALL retire in order on 2 consecutive edges, and wb_ready SHALL reassert.
REQ-031 Seven issues to dreg=1 SHALL set busy[1]=1 and iss_ready=0 for the 8th issue. An issue and a retire of code 1 in the same cycle SHALL be accepted with the counter held at 7. Seven retires SHALL return busy[1] to 0.
REQ-032 A write with dreg=14 and data=FFFF SHALL be accepted and SHALL leave all registers and busy unchanged.
REQ-033 Reset asserted while 2 entries are queued, one of them to ax=5555, SHALL give ax=0000 and an empty FIFO, with no later retirement.

Source files
------------

// File: rtl/cpu86_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu86_types_pkg
// Description : Shared register-code enumerations, reset constants and the
//               writeback entry layout for the cpu86 register reader/writer.
//               Also provides the helper that maps a writeback destination
//               onto its pending-counter slot.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu86_types_pkg;

    // Word destination codes (wb_w = 1)
    typedef enum logic [3:0] {
        RC_AX = 4'd0,
        RC_CX = 4'd1,
        RC_DX = 4'd2,
        RC_BX = 4'd3,
        RC_SP = 4'd4,
        RC_BP = 4'd5,
        RC_SI = 4'd6,
        RC_DI = 4'd7,
        RC_ES = 4'd8,
        RC_CS = 4'd9,
        RC_SS = 4'd10,
        RC_DS = 4'd11,
        RC_FL = 4'd12
    } reg_code_e;

    // Byte destination codes (wb_w = 0); bit 2 selects the high byte and
    // bits 1:0 select the parent register AX/CX/DX/BX.
    typedef enum logic [3:0] {
        RB_AL = 4'd0,
        RB_CL = 4'd1,
        RB_DL = 4'd2,
        RB_BL = 4'd3,
        RB_AH = 4'd4,
        RB_CH = 4'd5,
        RB_DH = 4'd6,
        RB_BH = 4'd7
    } byte_code_e;

    localparam int          NUM_REGS   = 13;
    localparam int          WB_ENTRY_W = 21;

    localparam logic [15:0] RST_GP     = 16'h0000;
    localparam logic [15:0] RST_CS     = 16'hFFFF;
    localparam logic [15:0] RST_FL     = 16'hF002;

    typedef struct packed {
        logic        w;
        logic [3:0]  dreg;
        logic [15:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } cnt_sel_t;

    // Pending-counter slot touched by a writeback; byte writes charge the
    // parent register, discarded codes charge nothing.
    function automatic cnt_sel_t cnt_sel(input logic w, input logic [3:0] dreg);
        cnt_sel_t s;
        if (w) begin
            s.valid = (dreg < 4'(NUM_REGS));
            s.idx   = dreg;
        end else begin
            s.valid = (dreg[3] == 1'b0);
            s.idx   = {2'b00, dreg[1:0]};
        end
        return s;
    endfunction

    function automatic logic [15:0] reset_value(input logic [3:0] code);
        logic [15:0] v;
        case (code)
            RC_CS:   v = RST_CS;
            RC_FL:   v = RST_FL;
            default: v = RST_GP;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu86_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cpu86_wb_fifo
// Description : Small synchronous FIFO holding accepted writeback requests.
// Ports       : clk, rst        - clock, async active-high reset
//               push, push_data - enqueue (ignored when full)
//               pop, pop_data   - dequeue head (ignored when empty)
//               empty, full     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cpu86_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = push_data;
            // Explicit wrap keeps non-power-of-two depths correct.
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu86_exec_register_writer.sv
`default_nettype none
// ============================================================================
// Module      : cpu86_exec_register_writer
// Description : Architectural register file write side. Writeback requests
//               are queued and retired one per cycle into the register file;
//               per-register pending counters track issue-side reservations.
// Ports       : clk, reset                     - clock, async active-high reset
//               wb_valid/wb_ready, wb_dreg,
//               wb_w, wb_data                  - writeback request
//               iss_valid/iss_ready, iss_dreg  - destination reservation
//               hold                           - freeze retirement
//               ax..fl                         - architectural registers
//               busy                           - per-code pending flag
// Revision    : 1.0 - initial release
// ============================================================================
module cpu86_exec_register_writer
    import cpu86_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_dreg,
    input  logic        wb_w,
    input  logic [15:0] wb_data,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [3:0]  iss_dreg,
    input  logic        hold,
    output logic [15:0] ax,
    output logic [15:0] bx,
    output logic [15:0] cx,
    output logic [15:0] dx,
    output logic [15:0] sp,
    output logic [15:0] bp,
    output logic [15:0] si,
    output logic [15:0] di,
    output logic [15:0] es,
    output logic [15:0] cs,
    output logic [15:0] ss,
    output logic [15:0] ds,
    output logic [15:0] fl,
    output logic [15:0] busy
);

    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];
    logic [2:0]  cnt_q  [NUM_REGS];
    logic [2:0]  cnt_d  [NUM_REGS];
    logic [15:0] busy_q, busy_d;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_retire;
    logic [WB_ENTRY_W-1:0] w_head_raw;
    wb_entry_t             w_head;
    wb_entry_t             w_push_entry;
    cnt_sel_t              w_ret_sel;
    logic                  w_iss_hs;
    logic [2:0]            w_iss_cnt;

    // ------------------------------------------------------------------------
    // Writeback queue
    // ------------------------------------------------------------------------
    assign wb_ready     = !w_full;
    assign w_push       = wb_valid && !w_full;
    assign w_push_entry = '{w: wb_w, dreg: wb_dreg, data: wb_data};
    assign w_retire     = !hold && !w_empty;
    assign w_head       = wb_entry_t'(w_head_raw);
    assign w_ret_sel    = cnt_sel(w_head.w, w_head.dreg);

    cpu86_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_retire),
        .pop_data  (w_head_raw),
        .empty     (w_empty),
        .full      (w_full)
    );

    // ------------------------------------------------------------------------
    // Register file update from the retiring head entry
    // ------------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (w_retire) begin
            if (w_head.w) begin
                if (w_head.dreg < 4'(NUM_REGS)) begin
                    regs_d[w_head.dreg] = w_head.data;
                end
            end else if (!w_head.dreg[3]) begin
                if (w_head.dreg[2]) begin
                    regs_d[{2'b00, w_head.dreg[1:0]}][15:8] = w_head.data[7:0];
                end else begin
                    regs_d[{2'b00, w_head.dreg[1:0]}][7:0]  = w_head.data[7:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending-reservation counters
    // ------------------------------------------------------------------------
    always_comb begin
        w_iss_cnt = 3'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (iss_dreg == 4'(i)) begin
                w_iss_cnt = cnt_q[i];
            end
        end
    end

    // A saturated counter can still take a reservation when the same code
    // retires this cycle, since the net change is zero.
    assign iss_ready = (w_iss_cnt != 3'd7) ||
                       (w_retire && w_ret_sel.valid && (w_ret_sel.idx == iss_dreg));
    assign w_iss_hs  = iss_valid && iss_ready;

    always_comb begin
        busy_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((w_iss_hs && (iss_dreg == 4'(i))) &&
                !(w_retire && w_ret_sel.valid && (w_ret_sel.idx == 4'(i)))) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end else if (!(w_iss_hs && (iss_dreg == 4'(i))) &&
                         (w_retire && w_ret_sel.valid && (w_ret_sel.idx == 4'(i))) &&
                         (cnt_q[i] != 3'd0)) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
            busy_d[i] = (cnt_d[i] != 3'd0);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(4'(i));
                cnt_q[i]  <= 3'd0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign ax   = regs_q[RC_AX];
    assign cx   = regs_q[RC_CX];
    assign dx   = regs_q[RC_DX];
    assign bx   = regs_q[RC_BX];
    assign sp   = regs_q[RC_SP];
    assign bp   = regs_q[RC_BP];
    assign si   = regs_q[RC_SI];
    assign di   = regs_q[RC_DI];
    assign es   = regs_q[RC_ES];
    assign cs   = regs_q[RC_CS];
    assign ss   = regs_q[RC_SS];
    assign ds   = regs_q[RC_DS];
    assign fl   = regs_q[RC_FL];
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu86_exec_register_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu86_exec_register_writer
// Description : Directed self-checking bench for cpu86_exec_register_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu86_exec_register_writer;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dreg;
    logic        wb_w;
    logic [15:0] wb_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_dreg;
    logic        hold;
    logic [15:0] ax, bx, cx, dx, sp, bp, si, di, es, cs, ss, ds, fl;
    logic [15:0] busy;

    int checks;
    int passes;

    // Order: ax cx dx bx sp bp si di es cs ss ds fl
    wire [207:0] all_regs = {ax, cx, dx, bx, sp, bp, si, di, es, cs, ss, ds, fl};
    localparam logic [207:0] RST_ALL = {{9{16'h0000}}, 16'hFFFF, 32'h0000_0000, 16'hF002};

    cpu86_exec_register_writer #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dreg   (wb_dreg),
        .wb_w      (wb_w),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_dreg  (iss_dreg),
        .hold      (hold),
        .ax        (ax),
        .bx        (bx),
        .cx        (cx),
        .dx        (dx),
        .sp        (sp),
        .bp        (bp),
        .si        (si),
        .di        (di),
        .es        (es),
        .cs        (cs),
        .ss        (ss),
        .ds        (ds),
        .fl        (fl),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (all_regs !== RST_ALL) $display("FAIL reset_regs: got %h want %h", all_regs, RST_ALL);
        else passes++;
        checks++;
        if (busy !== 16'h0000) $display("FAIL reset_busy: got %h want 0000", busy);
        else passes++;
        checks++;
        if ({wb_ready, iss_ready} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {wb_ready, iss_ready});
        else passes++;
    endtask

    task automatic test_word_byte();
        wb_valid = 1'b1; wb_w = 1'b1; wb_dreg = 4'd3; wb_data = 16'h1234;
        step();
        wb_valid = 1'b0;
        checks++;
        if (bx !== 16'h0000) $display("FAIL word_latency: bx got %h want 0000", bx);
        else passes++;
        step();
        checks++;
        if (bx !== 16'h1234) $display("FAIL word_write: bx got %h want 1234", bx);
        else passes++;
        wb_valid = 1'b1; wb_w = 1'b0; wb_dreg = 4'd7; wb_data = 16'h00AB;
        step();
        wb_valid = 1'b0;
        step();
        checks++;
        if (bx !== 16'hAB34) $display("FAIL byte_high: bx got %h want ab34", bx);
        else passes++;
        wb_valid = 1'b1; wb_w = 1'b0; wb_dreg = 4'd0; wb_data = 16'hFF77;
        step();
        wb_valid = 1'b0;
        step();
        checks++;
        if (ax !== 16'h0077) $display("FAIL byte_low: ax got %h want 0077", ax);
        else passes++;
    endtask

    task automatic test_hold_fifo();
        hold = 1'b1;
        wb_valid = 1'b1; wb_w = 1'b1; wb_dreg = 4'd1; wb_data = 16'h1111;
        step();
        wb_dreg = 4'd2; wb_data = 16'h2222;
        step();
        checks++;
        if (wb_ready !== 1'b0) $display("FAIL hold_full: wb_ready got %b want 0", wb_ready);
        else passes++;
        wb_dreg = 4'd6; wb_data = 16'h3333;
        step();
        checks++;
        if ({wb_ready, cx} !== {1'b0, 16'h0000}) $display("FAIL hold_frozen: ready/cx got %b/%h want 0/0000", wb_ready, cx);
        else passes++;
        hold = 1'b0;
        step();
        checks++;
        if ({cx, dx, wb_ready} !== {16'h1111, 16'h0000, 1'b1}) $display("FAIL drain_first: cx/dx/ready got %h/%h/%b want 1111/0000/1", cx, dx, wb_ready);
        else passes++;
        step();
        wb_valid = 1'b0;
        checks++;
        if (dx !== 16'h2222) $display("FAIL drain_second: dx got %h want 2222", dx);
        else passes++;
        step();
        checks++;
        if (si !== 16'h3333) $display("FAIL drain_third: si got %h want 3333", si);
        else passes++;
    endtask

    task automatic test_pending();
        iss_dreg = 4'd1;
        checks++;
        if (iss_ready !== 1'b1) $display("FAIL iss_idle: iss_ready got %b want 1", iss_ready);
        else passes++;
        iss_valid = 1'b1;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if ({busy[1], iss_ready} !== 2'b10) $display("FAIL iss_sat: busy1/iss_ready got %b want 10", {busy[1], iss_ready});
        else passes++;
        step();
        iss_valid = 1'b0;
        // Queue a code-1 write; its retirement coincides with a new issue.
        wb_valid = 1'b1; wb_w = 1'b1; wb_dreg = 4'd1; wb_data = 16'hBEEF;
        step();
        wb_valid = 1'b0;
        iss_valid = 1'b1;
        checks++;
        if (iss_ready !== 1'b1) $display("FAIL iss_bypass: iss_ready got %b want 1", iss_ready);
        else passes++;
        step();
        iss_valid = 1'b0;
        checks++;
        if ({cx, busy[1], iss_ready} !== {16'hBEEF, 1'b1, 1'b0}) $display("FAIL iss_hold7: cx/busy1/ready got %h/%b/%b want beef/1/0", cx, busy[1], iss_ready);
        else passes++;
        for (int i = 0; i < 7; i++) begin
            wb_valid = 1'b1;
            wb_w     = (i < 6);
            wb_dreg  = (i < 6) ? 4'd1 : 4'd5;
            wb_data  = (i < 6) ? (16'h1000 + 16'(i)) : 16'h00CD;
            step();
        end
        wb_valid = 1'b0;
        checks++;
        if (busy !== 16'h0002) $display("FAIL retire_six: busy got %h want 0002", busy);
        else passes++;
        step();
        checks++;
        if ({cx, busy, iss_ready} !== {16'hCD05, 16'h0000, 1'b1}) $display("FAIL retire_seven: cx/busy/ready got %h/%h/%b want cd05/0000/1", cx, busy, iss_ready);
        else passes++;
    endtask

    task automatic test_discard();
        logic [207:0] exp_all;
        exp_all = {16'h0077, 16'hCD05, 16'h2222, 16'hAB34, 16'h0000, 16'h0000,
                   16'h3333, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hF002};
        wb_valid = 1'b1; wb_w = 1'b1; wb_dreg = 4'd14; wb_data = 16'hFFFF;
        checks++;
        if (wb_ready !== 1'b1) $display("FAIL discard_accept: wb_ready got %b want 1", wb_ready);
        else passes++;
        step();
        wb_w = 1'b0; wb_dreg = 4'd9;
        step();
        wb_valid = 1'b0;
        step();
        step();
        checks++;
        if (all_regs !== exp_all) $display("FAIL discard_regs: got %h want %h", all_regs, exp_all);
        else passes++;
        checks++;
        if (busy !== 16'h0000) $display("FAIL discard_busy: got %h want 0000", busy);
        else passes++;
    endtask

    task automatic test_reset_midop();
        hold = 1'b1;
        wb_valid = 1'b1; wb_w = 1'b1; wb_dreg = 4'd0; wb_data = 16'h5555;
        step();
        wb_dreg = 4'd2; wb_data = 16'h9999;
        step();
        wb_valid = 1'b0;
        checks++;
        if ({wb_ready, ax} !== {1'b0, 16'h0077}) $display("FAIL midop_queued: ready/ax got %b/%h want 0/0077", wb_ready, ax);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if ({ax, wb_ready} !== {16'h0000, 1'b1}) $display("FAIL midop_async: ax/ready got %h/%b want 0000/1", ax, wb_ready);
        else passes++;
        step();
        reset = 1'b0;
        hold = 1'b0;
        step();
        step();
        step();
        checks++;
        if (all_regs !== RST_ALL) $display("FAIL midop_noretire: got %h want %h", all_regs, RST_ALL);
        else passes++;
        checks++;
        if ({wb_ready, iss_ready, busy} !== {2'b11, 16'h0000}) $display("FAIL midop_flags: got %b want 11_0000", {wb_ready, iss_ready, busy});
        else passes++;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        wb_valid  = 1'b0;
        wb_dreg   = 4'd0;
        wb_w      = 1'b0;
        wb_data   = 16'h0000;
        iss_valid = 1'b0;
        iss_dreg  = 4'd0;
        hold      = 1'b0;
        test_reset();
        test_word_byte();
        test_hold_fifo();
        test_pending();
        test_discard();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
